decoder_seq: RTL
================

Name: decoder_seq

Overview:
- Parametrised, registered successor to the team's 3-to-8 dataflow decoder: SEL_W-bit index -> one-hot OUT_W = 2**SEL_W output.
- Adds four modes: direct registered decode, auto-scan up, auto-scan down, and timed one-shot pulse.
- Drives row/digit selects, chip-select strobing and LED scanning in lab top-levels.
- Registered output, glitch-free.

Parameters:
- SEL_W, 3, index width; OUT_W = 2**SEL_W is derived (localparam). Legal range 1..6.
- DWELL, 4, cycles each output stays active per scan step; must be >= 1.
- PULSE_LEN, 3, cycles the output stays active in one-shot mode; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  global enable (the E of the combinational decoder)
- mode  input  2  00 direct, 01 scan up, 10 scan down, 11 one-shot
- sel  input  SEL_W  index for direct mode and one-shot load
- start  input  1  one-shot trigger, level-sampled each cycle
- out  output  OUT_W  registered one-hot (or all-zero) decode
- idx  output  SEL_W  registered current index; out == onehot(idx) whenever out != 0
- wrap  output  1  one-cycle pulse on scan wrap-around
- busy  output  1  high while a one-shot is active

Behaviour:
- Reset (async assert, sync release): out=0, idx=0, wrap=0, busy=0; internal dwell/pulse counter cnt=0.
- All state updates on the rising clk edge. out and idx always update on the same edge.
- Priority per cycle: reset > en=0 > mode change > mode action.
- en=0:
  - Next edge: out=0, wrap=0, busy=0 (aborts any one-shot), cnt=0.
  - idx holds.
- Mode change (mode differs from previous cycle's registered mode, en=1):
  - cnt=0, busy=0, wrap=0.
  - idx holds in scan modes; idx=sel in mode 00.
  - out=onehot(idx_new) in modes 00/01/10; out=0 in mode 11.
- Mode 00 direct:
  - Every edge: idx<=sel, out<=onehot(sel). Latency 1 cycle.
  - wrap=0, busy=0.
- Mode 01 scan up:
  - out=onehot(idx) continuously.
  - cnt counts 0..DWELL-1. On the edge where cnt==DWELL-1: cnt<=0, idx<=idx+1 mod OUT_W.
  - wrap<=1 for one cycle exactly when idx goes OUT_W-1 -> 0; otherwise wrap=0.
- Mode 10 scan down:
  - Same as scan up, but idx<=idx-1 mod OUT_W.
  - wrap pulses when idx goes 0 -> OUT_W-1.
- DWELL=1: idx advances every cycle; wrap pulses every OUT_W cycles.
- Mode 11 one-shot:
  - Idle (busy=0): out=0. If start=1: idx<=sel, out<=onehot(sel), busy<=1, cnt<=0.
  - Busy: cnt increments. On the edge where cnt==PULSE_LEN-1: out<=0, busy<=0, cnt<=0.
  - out is therefore high for exactly PULSE_LEN cycles.
  - start is ignored while busy=1.
  - start held high: re-triggers on the first cycle after busy falls, giving one idle cycle between pulses.
- Invariants:
  - out is always all-zero or exactly one-hot (popcount <= 1).
  - wrap is never high in modes 00/11.
  - busy is never high outside mode 11.
- Reset mid-operation: immediate async clear to reset values regardless of mode or counters.

Test Plan (SEL_W=3, DWELL=2, PULSE_LEN=3):
- Direct: reset, en=1, mode=00, sweep sel 0..7 -> out on the following edge = 8'h01,02,04,...,80; idx tracks sel; en=0 -> out=8'h00 next edge, idx holds.
- Scan up: mode=01 from idx=6 -> out 8'h40 for 2 cycles, 8'h80 for 2 cycles, then 8'h01 with wrap=1 for exactly one cycle; the next wrap comes 16 cycles later.
- Scan down: mode=10 from idx=1 -> out 8'h02 x2, 8'h01 x2, then 8'h80 with wrap=1 for one cycle; mid-dwell en=0 then en=1 restarts a full 2-cycle dwell at the held idx.
- One-shot: mode=11, sel=5, start pulse -> out=8'h20 and busy=1 for exactly 3 cycles, then 0; start asserted while busy -> no effect; start held high -> pulses of 3 active cycles separated by 1 idle cycle.
- Abort/reset: during a one-shot, switch to mode=00 -> busy=0, out=onehot(sel) next edge; assert rst_n=0 mid-scan (between edges) -> out=0, idx=0, wrap=0 immediately.
- Invariant check across a random mode/en/start/sel run: popcount(out)<=1; out==onehot(idx) whenever out!=0; wrap=0 outside modes 01/10; busy=0 outside mode 11.

Source files
------------

// File: rtl/decoder_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with direct, scan-up, scan-down
// and timed one-shot modes; out/idx/wrap/busy are all flop outputs.
module decoder_seq #(
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned DWELL     = 4,
    parameter int unsigned PULSE_LEN = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     start,
    output logic [(2**SEL_W)-1:0]    out,
    output logic [SEL_W-1:0]         idx,
    output logic                     wrap,
    output logic                     busy
);

    localparam int unsigned OUT_W   = 2 ** SEL_W;
    localparam int unsigned CNT_MAX = (DWELL > PULSE_LEN) ? DWELL : PULSE_LEN;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] MODE_DIRECT  = 2'b00;
    localparam logic [1:0] MODE_UP      = 2'b01;
    localparam logic [1:0] MODE_DOWN    = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(OUT_W - 1);

    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [SEL_W-1:0] idx_q,  idx_d;
    logic [OUT_W-1:0] out_q,  out_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, busy_d;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        onehot = OUT_W'(1) << i;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_DIRECT;
            cnt_q  <= '0;
            idx_q  <= '0;
            out_q  <= '0;
            wrap_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            out_q  <= out_d;
            wrap_q <= wrap_d;
            busy_q <= busy_d;
        end
    end

    // Next-state logic: en=0 beats a mode change, which beats the mode action
    always_comb begin
        mode_d = mode;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        out_d  = out_q;
        wrap_d = 1'b0;
        busy_d = busy_q;

        if (!en) begin
            out_d  = '0;
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (mode != mode_q) begin
            cnt_d  = '0;
            busy_d = 1'b0;
            if (mode == MODE_DIRECT) begin
                idx_d = sel;
            end
            out_d = (mode == MODE_ONESHOT) ? '0 : onehot(idx_d);
        end else begin
            unique case (mode)
                MODE_DIRECT: begin
                    idx_d  = sel;
                    out_d  = onehot(sel);
                    cnt_d  = '0;
                    busy_d = 1'b0;
                end
                MODE_UP, MODE_DOWN: begin
                    busy_d = 1'b0;
                    // Output dark (after reset or en=0): relight at the held index with a full dwell
                    if (out_q == '0) begin
                        cnt_d = '0;
                        out_d = onehot(idx_q);
                    end else if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (mode == MODE_UP) begin
                            idx_d  = idx_q + SEL_W'(1);
                            wrap_d = (idx_q == IDX_LAST);
                        end else begin
                            idx_d  = idx_q - SEL_W'(1);
                            wrap_d = (idx_q == '0);
                        end
                        out_d = onehot(idx_d);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        out_d = onehot(idx_q);
                    end
                end
                MODE_ONESHOT: begin
                    if (busy_q) begin
                        if (cnt_q == PULSE_LAST) begin
                            out_d  = '0;
                            busy_d = 1'b0;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (start) begin
                        idx_d  = sel;
                        out_d  = onehot(sel);
                        busy_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        out_d = '0;
                    end
                end
                default: begin
                    out_d = '0;
                end
            endcase
        end
    end

    // Outputs come straight from flops
    always_comb begin
        out  = out_q;
        idx  = idx_q;
        wrap = wrap_q;
        busy = busy_q;
    end

endmodule
